run_length_detector: RTL and testbench

Parametrised Mealy run-length detector for a serial symbol stream. It asserts `dout_bit` in the same cycle as the valid symbol that extends the current run of identical symbols to `RUN_LEN` or more. It also exposes the live run length, plus an optional detection-event counter. It sits directly behind the serial bit/symbol source, as the generalised replacement for the fixed "three-in-a-row" detector: any symbol width, any threshold, input qualifier, synchronous flush and a one-shot/retrigger mode.

---
 rtl/run_length_detector.sv | 130 +++++++++++++
 tb/tb_run_length_detector.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_detector.sv
// run_length_detector: Mealy run-length detector for a serial symbol stream.
// Ports: clk, reset (sync, active-high), clr (sync flush), din_valid, din[SYM_W]
//        -> dout_bit (same-cycle detect), run_len[CNT_W] (registered run count),
//        evt_cnt[EVT_W] (detection count, only with `RUN_DET_EVT_CNT_EN).
module run_length_detector #(
  parameter int unsigned SYM_W     = 1,
  parameter int unsigned RUN_LEN   = 3,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned RETRIGGER = 1,
  parameter int unsigned EVT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             din_valid,
  input  logic [SYM_W-1:0] din,
  output logic             dout_bit,
  output logic [CNT_W-1:0] run_len
`ifdef RUN_DET_EVT_CNT_EN
  ,
  output logic [EVT_W-1:0] evt_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(RUN_LEN);

  state_e           state_q, state_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             match;
  logic             accept;
  logic             hit;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] n_cnt;

  // Count the incoming symbol would give the run; shared by the
  // detect output and the state update so they can never disagree.
  always_comb begin
    match   = (state_q == RUN) && (din == sym_q);
    cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    n_cnt   = match ? cnt_inc : CNT_ONE;
    accept  = !reset && !clr && din_valid;
  end

  // Retrigger compares >= so saturated runs keep firing; one-shot
  // compares == so a saturated run stays silent until it breaks.
  always_comb begin
    if (RETRIGGER != 0) begin
      hit = (n_cnt >= THRESH);
    end else begin
      hit = (n_cnt == THRESH);
    end
  end

  assign dout_bit = accept && hit;

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      sym_d   = '0;
      cnt_d   = '0;
    end else if (din_valid) begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          sym_d   = din;
          cnt_d   = CNT_ONE;
        end
        RUN: begin
          state_d = RUN;
          sym_d   = din;
          cnt_d   = n_cnt;
        end
        default: begin
          state_d = IDLE;
          sym_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sym_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run_len = cnt_q;

`ifdef RUN_DET_EVT_CNT_EN
  logic [EVT_W-1:0] evt_q, evt_d;

  // Wraps modulo 2^EVT_W; clr deliberately leaves it alone.
  always_comb begin
    evt_d = evt_q;
    if (dout_bit) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt_cnt = evt_q;
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: six parameter variants driven in lockstep and
// checked against a symbol-history reference model.
module tb_run_length_detector;

  localparam int NI = 6;
  localparam int PS [NI] = '{1, 1, 1, 1, 4, 1};
  localparam int PL [NI] = '{3, 3, 2, 2, 3, 1};
  localparam int PC [NI] = '{4, 4, 2, 2, 4, 4};
  localparam int PR [NI] = '{1, 0, 1, 0, 1, 0};
  localparam int HN = 32;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       din_valid;
  logic [3:0] din;

  logic       dout [NI];
  logic [3:0] rl   [NI];
`ifdef RUN_DET_EVT_CNT_EN
  logic [15:0] ev  [NI];
`endif

  int n_tests;
  int n_fail;

  logic [3:0] hist [NI][HN];
  int         hn   [NI];
  int         evm  [NI];
  logic       exp_dout [NI];
  int         exp_rl   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic             d_w;
    logic [PC[g]-1:0] rl_w;
`ifdef RUN_DET_EVT_CNT_EN
    logic [15:0]      ev_w;
`endif
    run_length_detector #(
      .SYM_W    (PS[g]),
      .RUN_LEN  (PL[g]),
      .CNT_W    (PC[g]),
      .RETRIGGER(PR[g]),
      .EVT_W    (16)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr),
      .din_valid(din_valid),
      .din      (din[PS[g]-1:0]),
      .dout_bit (d_w),
      .run_len  (rl_w)
`ifdef RUN_DET_EVT_CNT_EN
      ,
      .evt_cnt  (ev_w)
`endif
    );
    assign dout[g] = d_w;
    assign rl[g]   = 4'(rl_w);
`ifdef RUN_DET_EVT_CNT_EN
    assign ev[g]   = ev_w;
`endif
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] msk(int i, logic [3:0] d);
    return d & 4'((1 << PS[i]) - 1);
  endfunction

  function automatic int sat(int i, int x);
    int mx;
    mx = (1 << PC[i]) - 1;
    return (x > mx) ? mx : x;
  endfunction

  // Number of most recent accepted symbols equal to s.
  function automatic int trail(int i, logic [3:0] s);
    int c;
    c = 0;
    for (int k = hn[i] - 1; k >= 0; k--) begin
      if (hist[i][k] != s) break;
      c++;
    end
    return c;
  endfunction

  task automatic drive(input logic r, input logic c, input logic v,
                       input logic [3:0] d);
    int n;
    @(negedge clk);
    reset = r;
    clr = c;
    din_valid = v;
    din = d;
    #1;
    for (int i = 0; i < NI; i++) begin
      n = sat(i, trail(i, msk(i, d)) + 1);
      exp_dout[i] = !r && !c && v &&
                    ((PR[i] != 0) ? (n >= PL[i]) : (n == PL[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        hn[i] = 0;
        evm[i] = 0;
      end else if (clr) begin
        hn[i] = 0;
      end else if (din_valid) begin
        if (exp_dout[i]) evm[i] = (evm[i] + 1) % 65536;
        if (hn[i] == HN) begin
          for (int k = 0; k < HN - 1; k++) hist[i][k] = hist[i][k+1];
          hn[i] = HN - 1;
        end
        hist[i][hn[i]] = msk(i, din);
        hn[i]++;
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_rl[i] = (hn[i] == 0) ? 0 : sat(i, trail(i, hist[i][hn[i]-1]));
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (dout[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_dout u%0d: got %0b want 0", i, dout[i]);
      end
    end
    tick();
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (rl[i] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_run_len u%0d: got %0d want 0", i, rl[i]);
      end
`ifdef RUN_DET_EVT_CNT_EN
      n_tests++;
      if (ev[i] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_evt u%0d: got %0d want 0", i, ev[i]);
      end
`endif
    end
  endtask

  task automatic test_basic();
    logic [3:0] sd [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    logic       ed [8] = '{0, 0, 1, 1, 0, 0, 1, 0};
    int         er [8] = '{1, 2, 3, 4, 1, 2, 3, 1};
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b1, sd[k]);
      n_tests++;
      if (dout[0] !== ed[k]) begin
        n_fail++;
        $display("FAIL basic_dout k%0d: got %0b want %0b", k, dout[0], ed[k]);
      end
      for (int i = 1; i < NI; i++) begin
        n_tests++;
        if (dout[i] !== exp_dout[i]) begin
          n_fail++;
          $display("FAIL basic_model_dout u%0d k%0d: got %0b want %0b",
                   i, k, dout[i], exp_dout[i]);
        end
      end
      tick();
      n_tests++;
      if (rl[0] !== 4'(er[k])) begin
        n_fail++;
        $display("FAIL basic_run_len k%0d: got %0d want %0d", k, rl[0], er[k]);
      end
    end
  endtask

  task automatic test_oneshot_sat();
    logic e1 [6] = '{0, 0, 1, 0, 0, 0};
    logic e2 [6] = '{0, 1, 1, 1, 1, 1};
    logic e3 [6] = '{0, 1, 0, 0, 0, 0};
    int   r2 [6] = '{1, 2, 3, 3, 3, 3};
    drive(1'b0, 1'b1, 1'b1, 4'd1);
    for (int i = 0; i < NI; i++) begin
      n_tests++;
      if (dout[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_dout u%0d: got %0b want 0", i, dout[i]);
      end
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd1);
      n_tests += 3;
      if (dout[1] !== e1[k]) begin
        n_fail++;
        $display("FAIL oneshot_dout k%0d: got %0b want %0b", k, dout[1], e1[k]);
      end
      if (dout[2] !== e2[k]) begin
        n_fail++;
        $display("FAIL sat_retrig_dout k%0d: got %0b want %0b", k, dout[2], e2[k]);
      end
      if (dout[3] !== e3[k]) begin
        n_fail++;
        $display("FAIL sat_oneshot_dout k%0d: got %0b want %0b", k, dout[3], e3[k]);
      end
      tick();
      n_tests += 2;
      if (rl[2] !== 4'(r2[k])) begin
        n_fail++;
        $display("FAIL sat_run_len_u2 k%0d: got %0d want %0d", k, rl[2], r2[k]);
      end
      if (rl[3] !== 4'(r2[k])) begin
        n_fail++;
        $display("FAIL sat_run_len_u3 k%0d: got %0d want %0d", k, rl[3], r2[k]);
      end
    end
  endtask

  task automatic test_gaps();
    logic sv [6] = '{1, 0, 0, 1, 0, 1};
    logic ed [6] = '{0, 0, 0, 0, 0, 1};
    int   er [6] = '{1, 1, 1, 2, 2, 3};
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, sv[k], sv[k] ? 4'd0 : 4'($urandom_range(0, 15)));
      n_tests++;
      if (dout[0] !== ed[k]) begin
        n_fail++;
        $display("FAIL gaps_dout k%0d: got %0b want %0b", k, dout[0], ed[k]);
      end
      tick();
      n_tests++;
      if (rl[0] !== 4'(er[k])) begin
        n_fail++;
        $display("FAIL gaps_run_len k%0d: got %0d want %0d", k, rl[0], er[k]);
      end
    end
  endtask

  task automatic test_clr_wide();
    logic [3:0] sd [4] = '{4'hA, 4'hA, 4'hA, 4'h5};
    logic       sc [4] = '{0, 0, 1, 0};
    int         er [4] = '{1, 2, 0, 1};
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, sc[k], 1'b1, sd[k]);
      n_tests++;
      if (dout[4] !== 1'b0) begin
        n_fail++;
        $display("FAIL wide_dout k%0d: got %0b want 0", k, dout[4]);
      end
      tick();
      n_tests++;
      if (rl[4] !== 4'(er[k])) begin
        n_fail++;
        $display("FAIL wide_run_len k%0d: got %0d want %0d", k, rl[4], er[k]);
      end
    end
  endtask

`ifdef RUN_DET_EVT_CNT_EN
  task automatic test_evt();
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd0);
      tick();
    end
    n_tests++;
    if (ev[0] !== 16'd8) begin
      n_fail++;
      $display("FAIL evt_count: got %0d want 8", ev[0]);
    end
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    n_tests++;
    if (ev[0] !== 16'd8) begin
      n_fail++;
      $display("FAIL evt_after_clr: got %0d want 8", ev[0]);
    end
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    n_tests += 2;
    if (ev[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL evt_after_reset: got %0d want 0", ev[0]);
    end
    if (rl[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL run_len_after_reset: got %0d want 0", rl[0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] pd;
    logic [3:0] d;
    logic       r;
    logic       c;
    logic       v;
    pd = 4'd0;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 75);
      d = ($urandom_range(0, 99) < 85) ? pd : 4'($urandom_range(0, 15));
      pd = d;
      drive(r, c, v, d);
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (dout[i] !== exp_dout[i]) begin
          n_fail++;
          $display("FAIL rand_dout u%0d k%0d: got %0b want %0b",
                   i, k, dout[i], exp_dout[i]);
        end
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        n_tests++;
        if (rl[i] !== 4'(exp_rl[i])) begin
          n_fail++;
          $display("FAIL rand_run_len u%0d k%0d: got %0d want %0d",
                   i, k, rl[i], exp_rl[i]);
        end
`ifdef RUN_DET_EVT_CNT_EN
        n_tests++;
        if (ev[i] !== 16'(evm[i])) begin
          n_fail++;
          $display("FAIL rand_evt u%0d k%0d: got %0d want %0d",
                   i, k, ev[i], evm[i]);
        end
`endif
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset = 1'b1;
    clr = 1'b0;
    din_valid = 1'b0;
    din = 4'd0;
    for (int i = 0; i < NI; i++) begin
      hn[i] = 0;
      evm[i] = 0;
      exp_dout[i] = 1'b0;
      exp_rl[i] = 0;
    end
    test_reset();
    test_basic();
    test_oneshot_sat();
    test_gaps();
    test_clr_wide();
`ifdef RUN_DET_EVT_CNT_EN
    test_evt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
